// File: rtl/histo_pkg.sv
// Shared definitions for the signed histogram accumulator.
//   cnt_width : signed width needed for one beat's per-bin count (-lanes..+lanes)
//   sat_add   : saturating signed add, clamped to an acc_w-bit signed range
//   sat_hit   : 1 when sat_add had to clamp
//   MODE_*    : encodings of the Mode input
package histo_pkg;

   localparam logic MODE_SIGNED = 1'b0;
   localparam logic MODE_MAG    = 1'b1;

   function automatic int unsigned cnt_width(input int unsigned lanes);
      return $clog2(lanes) + 2;
   endfunction

   function automatic int sat_add(input int acc, input int cnt, input int unsigned acc_w);
      int hi;
      int lo;
      int sum;
      hi  = (1 <<< (acc_w - 1)) - 1;
      lo  = -hi - 1;
      sum = acc + cnt;
      if (sum > hi) begin
         return hi;
      end else if (sum < lo) begin
         return lo;
      end
      return sum;
   endfunction

   function automatic logic sat_hit(input int acc, input int cnt, input int unsigned acc_w);
      return sat_add(acc, cnt, acc_w) != (acc + cnt);
   endfunction

endpackage

// File: rtl/lane_signed_popcount.sv
// Signed population count of one histogram bin across all lanes.
//   column : per-lane bit for this bin
//   sign   : per-lane product sign, 1 = negative
//   mask   : per-lane participation
//   mode   : MODE_SIGNED counts +1/-1, MODE_MAG counts +1 regardless of sign
//   count  : signed sum, range -LANES..+LANES
// Built as a recursive binary adder tree; LANES must be a power of two.
module lane_signed_popcount
   import histo_pkg::*;
#(
   parameter int unsigned LANES = 16,
   parameter int unsigned CNT_W = 6
) (
   input  logic [LANES-1:0]        column,
   input  logic [LANES-1:0]        sign,
   input  logic [LANES-1:0]        mask,
   input  logic                    mode,
   output logic signed [CNT_W-1:0] count
);

   if (LANES == 1) begin : g_leaf
      logic active;
      logic neg;

      assign active = column[0] & mask[0];

      always_comb begin
         neg = 1'b0;
         case (mode)
            MODE_SIGNED: neg = sign[0];
            MODE_MAG:    neg = 1'b0;
         endcase
      end

      assign count = !active ? '0 : (neg ? '1 : CNT_W'(1));
   end else begin : g_node
      localparam int unsigned HALF = LANES / 2;

      logic signed [CNT_W-1:0] cnt_lo;
      logic signed [CNT_W-1:0] cnt_hi;

      lane_signed_popcount #(
         .LANES(HALF),
         .CNT_W(CNT_W)
      ) u_lo (
         .column(column[HALF-1:0]),
         .sign  (sign[HALF-1:0]),
         .mask  (mask[HALF-1:0]),
         .mode  (mode),
         .count (cnt_lo)
      );

      lane_signed_popcount #(
         .LANES(HALF),
         .CNT_W(CNT_W)
      ) u_hi (
         .column(column[LANES-1:HALF]),
         .sign  (sign[LANES-1:HALF]),
         .mask  (mask[LANES-1:HALF]),
         .mode  (mode),
         .count (cnt_hi)
      );

      assign count = cnt_lo + cnt_hi;
   end

endmodule

// File: rtl/signed_histogram_accumulator.sv
// Pipelined per-bit-position signed histogram with group accumulation.
//   clk, rst_n          : clock, synchronous active-low reset
//   InValid/InReady     : input beat handshake
//   OneHotVector        : LANES rows of BITS, lane l bin b at [l*BITS+b]
//   MultipliedSign      : per-lane sign, LaneMask: per-lane enable, Mode: signed/magnitude
//   InFirst/InLast      : group delimiters
//   OutValid/OutReady   : histogram handshake
//   Histogram           : BITS signed ACC_W bins, bin b at [b*ACC_W +: ACC_W]
//   Overflow            : per-bin saturation flag of the emitted group
// S1 registers per-bin beat counts; S2 accumulates them with saturation and
// loads the output register on the group's last beat.
module signed_histogram_accumulator
   import histo_pkg::*;
#(
   parameter int unsigned LANES = 16,
   parameter int unsigned BITS  = 16,
   parameter int unsigned ACC_W = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic [LANES*BITS-1:0] OneHotVector,
   input  logic [LANES-1:0]      MultipliedSign,
   input  logic [LANES-1:0]      LaneMask,
   input  logic                  Mode,
   input  logic                  InFirst,
   input  logic                  InLast,
   output logic                  OutValid,
   input  logic                  OutReady,
   output logic [BITS*ACC_W-1:0] Histogram,
   output logic [BITS-1:0]       Overflow
);

   localparam int unsigned CNT_W = cnt_width(LANES);

   logic signed [CNT_W-1:0] cnt_c    [BITS];
   logic signed [CNT_W-1:0] s1_cnt_q [BITS];
   logic                    s1_valid_q;
   logic                    s1_first_q;
   logic                    s1_last_q;

   logic signed [ACC_W-1:0] acc_q  [BITS];
   logic signed [ACC_W-1:0] acc_d  [BITS];
   logic signed [ACC_W-1:0] hist_q [BITS];
   logic [BITS-1:0]         ovf_q;
   logic [BITS-1:0]         ovf_d;
   logic [BITS-1:0]         ovf_out_q;
   logic                    out_valid_q;

   logic                    s1_adv;
   logic                    in_fire;

   for (genvar b = 0; b < BITS; b++) begin : g_bin
      logic [LANES-1:0] column;

      for (genvar l = 0; l < LANES; l++) begin : g_lane
         assign column[l] = OneHotVector[l*BITS + b];
      end

      lane_signed_popcount #(
         .LANES(LANES),
         .CNT_W(CNT_W)
      ) u_pop (
         .column(column),
         .sign  (MultipliedSign),
         .mask  (LaneMask),
         .mode  (Mode),
         .count (cnt_c[b])
      );

      assign Histogram[b*ACC_W +: ACC_W] = hist_q[b];
   end

   // A last beat may only leave S1 when the output register is free or draining.
   assign s1_adv   = s1_valid_q && !(s1_last_q && out_valid_q && !OutReady);
   assign InReady  = !s1_valid_q || s1_adv;
   assign in_fire  = InValid && InReady;
   assign OutValid = out_valid_q;
   assign Overflow = ovf_out_q;

   // First restarts both the sum and the sticky flag before this beat's update.
   always_comb begin
      for (int b = 0; b < BITS; b++) begin
         acc_d[b] = ACC_W'(sat_add(s1_first_q ? 0 : int'(acc_q[b]), int'(s1_cnt_q[b]), ACC_W));
         ovf_d[b] = (!s1_first_q && ovf_q[b]) ||
                    sat_hit(s1_first_q ? 0 : int'(acc_q[b]), int'(s1_cnt_q[b]), ACC_W);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         ovf_q       <= '0;
         ovf_out_q   <= '0;
         for (int b = 0; b < BITS; b++) begin
            s1_cnt_q[b] <= '0;
            acc_q[b]    <= '0;
            hist_q[b]   <= '0;
         end
      end else begin
         if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_first_q <= InFirst;
            s1_last_q  <= InLast;
            s1_cnt_q   <= cnt_c;
         end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
         end

         if (s1_adv && s1_last_q) begin
            hist_q      <= acc_d;
            ovf_out_q   <= ovf_d;
            out_valid_q <= 1'b1;
            ovf_q       <= '0;
            for (int b = 0; b < BITS; b++) begin
               acc_q[b] <= '0;
            end
         end else begin
            if (s1_adv) begin
               acc_q <= acc_d;
               ovf_q <= ovf_d;
            end
            if (OutReady) begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_signed_histogram_accumulator.sv
module tb_signed_histogram_accumulator;

   localparam int L  = 16;
   localparam int B  = 16;
   localparam int WA = 10;
   localparam int WB = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic           in_valid;
   logic [L*B-1:0] one_hot;
   logic [L-1:0]   sign;
   logic [L-1:0]   mask;
   logic           mode;
   logic           first;
   logic           last;
   logic           out_ready;

   logic            ready_a, ready_b, ov_a, ov_b;
   logic [B*WA-1:0] hist_a;
   logic [B*WB-1:0] hist_b;
   logic [B-1:0]    ovf_a, ovf_b;

   signed_histogram_accumulator #(.LANES(L), .BITS(B), .ACC_W(WA)) dut_a (
      .clk(clk), .rst_n(rst_n), .InValid(in_valid), .InReady(ready_a),
      .OneHotVector(one_hot), .MultipliedSign(sign), .LaneMask(mask), .Mode(mode),
      .InFirst(first), .InLast(last), .OutValid(ov_a), .OutReady(out_ready),
      .Histogram(hist_a), .Overflow(ovf_a)
   );

   signed_histogram_accumulator #(.LANES(L), .BITS(B), .ACC_W(WB)) dut_b (
      .clk(clk), .rst_n(rst_n), .InValid(in_valid), .InReady(ready_b),
      .OneHotVector(one_hot), .MultipliedSign(sign), .LaneMask(mask), .Mode(mode),
      .InFirst(first), .InLast(last), .OutValid(ov_b), .OutReady(out_ready),
      .Histogram(hist_b), .Overflow(ovf_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int bin_a(input int b);
      return $signed(hist_a[b*WA +: WA]);
   endfunction

   function automatic int bin_b(input int b);
      return $signed(hist_b[b*WB +: WB]);
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic [B*WA-1:0] ha;
      logic [B*WB-1:0] hb;
      logic [B-1:0]    oa;
      logic [B-1:0]    ob;
   } exp_t;

   exp_t sb[$];
   int   macc [2][B];
   bit   movf [2][B];

   function automatic int clampw(input int v, input int w);
      int hi = (1 <<< (w - 1)) - 1;
      int lo = -(1 <<< (w - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   task automatic model_reset();
      sb.delete();
      for (int k = 0; k < 2; k++) begin
         for (int b = 0; b < B; b++) begin
            macc[k][b] = 0;
            movf[k][b] = 1'b0;
         end
      end
   endtask

   task automatic model_beat();
      exp_t e;
      for (int b = 0; b < B; b++) begin
         int c = 0;
         for (int l = 0; l < L; l++) begin
            if (one_hot[l*B + b] && mask[l]) c += (mode || !sign[l]) ? 1 : -1;
         end
         for (int k = 0; k < 2; k++) begin
            int w = (k == 0) ? WA : WB;
            int s = (first ? 0 : macc[k][b]) + c;
            bit o = first ? 1'b0 : movf[k][b];
            if (clampw(s, w) != s) o = 1'b1;
            macc[k][b] = clampw(s, w);
            movf[k][b] = o;
         end
      end
      if (last) begin
         for (int b = 0; b < B; b++) begin
            e.ha[b*WA +: WA] = macc[0][b][WA-1:0];
            e.hb[b*WB +: WB] = macc[1][b][WB-1:0];
            e.oa[b] = movf[0][b];
            e.ob[b] = movf[1][b];
         end
         sb.push_back(e);
         for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < B; b++) begin
               macc[k][b] = 0;
               movf[k][b] = 1'b0;
            end
         end
      end
   endtask

   // Every visible histogram must match the oldest outstanding group.
   always @(negedge clk) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         if (ov_a || ov_b) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: OutValid a=%0b b=%0b with no group due", ov_a, ov_b);
            end else begin
               chk("sb_valid_b", ov_b, ov_a);
               chk("sb_hist_a", hist_a, sb[0].ha);
               chk("sb_ovf_a", ovf_a, sb[0].oa);
               chk("sb_hist_b", hist_b, sb[0].hb);
               chk("sb_ovf_b", ovf_b, sb[0].ob);
               if (out_ready) void'(sb.pop_front());
            end
         end
         if (in_valid && ready_a) model_beat();
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int pos, input logic [15:0] sg, input logic [15:0] msk,
                           input logic md, input logic f, input logic lst);
      one_hot = '0;
      for (int l = 0; l < L; l++) begin
         if (pos >= 0) one_hot[l*B + pos] = 1'b1;
      end
      sign  = sg;
      mask  = msk;
      mode  = md;
      first = f;
      last  = lst;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send();
      bit ok = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ready_a) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ov_a) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("wait_out_timeout", 0, 1);
   endtask

   typedef struct {
      int          pos;
      logic [15:0] sg;
      logic [15:0] msk;
      logic        md;
      int          exp_v;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{3,  16'h00FF, 16'hFFFF, 1'b0, 0};
      tbl[1] = '{3,  16'h00FF, 16'hFFFF, 1'b1, 16};
      tbl[2] = '{3,  16'h00FF, 16'h000F, 1'b1, 4};
      tbl[3] = '{3,  16'h00FF, 16'h000F, 1'b0, -4};
      tbl[4] = '{15, 16'hFFFF, 16'hFFFF, 1'b0, -16};
      tbl[5] = '{0,  16'h0000, 16'hFFFF, 1'b0, 16};
      tbl[6] = '{7,  16'hF000, 16'hFFFF, 1'b0, 8};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      set_beat(-1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_outvalid_a", ov_a, 0);
      chk("rst_outvalid_b", ov_b, 0);
      chk("rst_inready", ready_a, 1);
      chk("rst_hist_a", hist_a, 0);
      chk("rst_hist_b", hist_b, 0);
      chk("rst_ovf", ovf_a, 0);

      // Single-beat groups: latency and bin value
      for (int i = 0; i < 7; i++) begin
         tick();
         set_beat(tbl[i].pos, tbl[i].sg, tbl[i].msk, tbl[i].md, 1'b1, 1'b1);
         in_valid = 1'b1;
         @(negedge clk);
         chk("tbl_inready", ready_a, 1);
         tick();
         in_valid = 1'b0;
         @(negedge clk);
         chk("tbl_lat1_novalid", ov_a, 0);
         @(negedge clk);
         chk("tbl_lat2_valid", ov_a, 1);
         chk("tbl_bin_a", bin_a(tbl[i].pos), tbl[i].exp_v);
         chk("tbl_bin_b", bin_b(tbl[i].pos), tbl[i].exp_v);
         chk("tbl_ovf_a", ovf_a, 0);
      end
      tick();

      // Four-beat group at bin 0
      for (int j = 0; j < 4; j++) begin
         set_beat(0, 16'h0, 16'hFFFF, 1'b0, j == 0, j == 3);
         send();
      end
      wait_out();
      chk("grp4_bin_a", bin_a(0), 64);
      chk("grp4_ovf_a", ovf_a, 0);
      chk("grp4_bin_b", bin_b(0), 31);
      chk("grp4_ovf_b", ovf_b, 16'h0001);
      tick();

      // Saturation then recovery at bin 7
      for (int j = 0; j < 3; j++) begin
         set_beat(7, 16'h0, 16'hFFFF, 1'b0, j == 0, j == 2);
         send();
      end
      wait_out();
      chk("sat_bin_a", bin_a(7), 48);
      chk("sat_bin_b", bin_b(7), 31);
      chk("sat_ovf_b", ovf_b, 16'h0080);
      tick();
      set_beat(7, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
      send();
      wait_out();
      chk("unsat_bin_b", bin_b(7), -16);
      chk("unsat_ovf_b", ovf_b, 0);
      tick();

      // Backpressure: two groups queued behind a stalled output
      out_ready = 1'b0;
      set_beat(1, 16'h0, 16'hFFFF, 1'b1, 1'b1, 1'b1);
      send();
      set_beat(2, 16'h0, 16'hFFFF, 1'b1, 1'b1, 1'b1);
      send();
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("bp_valid", ov_a, 1);
         chk("bp_inready_low", ready_a, 0);
         chk("bp_hold_bin", bin_a(1), 16);
      end
      tick();
      set_beat(5, 16'h0, 16'hFFFF, 1'b0, 1'b1, 1'b1);
      out_ready = 1'b1;
      send();
      @(negedge clk);
      chk("bp_second_valid", ov_a, 1);
      chk("bp_second_bin", bin_a(2), 16);
      repeat (4) tick();
      chk("bp_drained", sb.size(), 0);

      // Reset mid-group: pre-reset beats must not leak into the next group
      set_beat(4, 16'h0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      send();
      set_beat(4, 16'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      send();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstmid_valid", ov_a, 0);
      chk("rstmid_inready", ready_a, 1);
      tick();
      set_beat(4, 16'h0, 16'h000F, 1'b1, 1'b0, 1'b1);
      send();
      wait_out();
      chk("rstmid_bin_a", bin_a(4), 4);
      chk("rstmid_bin_b", bin_b(4), 4);
      tick();

      // Reset while a result is being held
      out_ready = 1'b0;
      set_beat(6, 16'h0, 16'hFFFF, 1'b1, 1'b1, 1'b1);
      send();
      wait_out();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("rstout_valid", ov_a, 0);
      chk("rstout_hist", hist_a, 0);
      tick();
      set_beat(6, 16'h0, 16'h0003, 1'b1, 1'b1, 1'b1);
      send();
      wait_out();
      chk("rstout_bin_a", bin_a(6), 2);
      tick();

      // Randomised traffic against the scoreboard
      for (int c = 0; c < 400; c++) begin
         one_hot = '0;
         for (int l = 0; l < L; l++) begin
            int r = $urandom_range(19);
            if (r < 16) one_hot[l*B + r] = 1'b1;
            if (r == 19) begin
               one_hot[l*B + $urandom_range(15)] = 1'b1;
               one_hot[l*B + $urandom_range(15)] = 1'b1;
            end
         end
         sign      = 16'($urandom);
         mask      = 16'($urandom);
         mode      = 1'($urandom_range(1));
         first     = ($urandom_range(5) == 0);
         last      = ($urandom_range(2) == 0);
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      chk("rand_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/signed_histogram_accumulator.md
Name: signed_histogram_accumulator

Overview:
Parametrised, pipelined successor of the combinational per-bit-position signed histogram stage in the PE. Each beat carries LANES one-hot bit-position vectors and per-lane product signs. The block counts +1/-1 contributions per bit position and accumulates them over a multi-beat group delimited by InFirst/InLast. It emits one saturated histogram per group to the alignment stage through a valid/ready handshake.

Parameters:
LANES, 16, number of products per beat (power of two, 2..64)
BITS, 16, number of bit positions (histogram bins)
ACC_W, 10, signed accumulator width per bin (>= CNT_W)
CNT_W, $clog2(LANES)+2, derived; signed width of one beat's per-bin count (localparam, not overridable)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
InValid  in  1  input beat valid
InReady  out  1  input beat accepted when InValid&&InReady
OneHotVector  in  LANES x BITS  per-lane one-hot (or zero) bit-position vector
MultipliedSign  in  LANES  per-lane sign, 1 = negative
LaneMask  in  LANES  1 = lane participates
Mode  in  1  0 = signed count (+1/-1), 1 = magnitude count (sign ignored)
InFirst  in  1  first beat of a group
InLast  in  1  last beat of a group
OutValid  out  1  histogram available
OutReady  in  1  downstream accepts histogram
Histogram  out  BITS x ACC_W  signed per-bin totals
Overflow  out  BITS  per-bin sticky saturation flag for the emitted group

Behaviour:
- Clock is clk; reset is synchronous, active-low on rst_n. Reset values: OutValid=0, Histogram=0, Overflow=0, S1 valid=0, accumulators=0. InReady=1 in the cycle after reset is released.
- Reset mid-group discards the partial group and any unconsumed output.
- Stage S1 (registered): for each bin b, plus = popcount over lanes l of OneHot[l][b]&Mask[l]&(Mode|!Sign[l]); minus = popcount of OneHot[l][b]&Mask[l]&!Mode&Sign[l]; count = plus-minus, signed CNT_W. Range is -LANES..+LANES. S1 also registers First and Last.
- Stage S2 (accumulate): on an S1 advance, acc_b = (First ? 0 : acc_b) + sext(count_b), saturating to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A saturation event sets ovf_b. First also clears ovf_b before the update.
- On an S1 advance with Last: the final sums (including this beat) and ovf load into Histogram/Overflow, and OutValid rises the next cycle. The accumulator and ovf clear. First and Last in the same beat form a valid one-beat group.
- Latency: input accept to OutValid = 2 cycles for a single-beat group.
- Output hold: Histogram/Overflow are stable while OutValid && !OutReady. OutValid falls the cycle after the handshake unless a new Last loads in that same cycle, in which case it stays 1 with the new data.
- Stall: S1 cannot advance when S1 holds Last and OutValid && !OutReady. InReady = !S1valid || S1 can advance. The bubble-free full-rate case: back-to-back groups with OutReady tied 1 sustain one beat per cycle.
- Beat without InFirst as the first beat after a Last: it accumulates onto the cleared accumulator (equivalent to First).
- A beat with InValid=0 leaves all state unchanged.
- OneHotVector rows with more than one bit set are counted per set bit; the block does not check them.

Decomposition:
- Package histo_pkg: function clog2-based CNT_W helper, saturating-add function sat_add(acc, cnt) parametrised by ACC_W, and constants for Mode encodings (MODE_SIGNED=0, MODE_MAG=1).
- Sub-module lane_signed_popcount (LANES, CNT_W): combinational, one bin, inputs column/sign/mask/mode, output signed count via a recursive adder tree. Instantiated BITS times.

Test Plan:
- Reset release, then one beat with First=Last=1, LANES=16, all lanes one-hot at bit 3, signs 0x00FF, Mode=0 -> OutValid at cycle +2, Histogram[3]=0, other bins 0, Overflow=0.
- Same beat with Mode=1 -> Histogram[3]=16. With LaneMask=0x000F and Mode=1 -> Histogram[3]=4.
- 4-beat group, each beat all 16 lanes at bit 0 positive -> Histogram[0]=64, emitted once, after the 4th beat only.
- ACC_W=6, 3 beats of +16 at bit 7 -> Histogram[7]=31, Overflow[7]=1. The next group of one -16 beat -> Histogram[7]=-16, Overflow=0.
- Backpressure: OutReady=0 while two single-beat groups are offered -> the first is held stable, InReady drops with the second Last in S1. Raise OutReady -> the second group is emitted and nothing is lost or duplicated.
- Assert rst_n=0 for one cycle mid-group and while OutValid=1 -> OutValid=0, and the next group result excludes the pre-reset beats.
